execute_unit: RTL and testbench

- Pipeline execute stage, directly upstream of the memory unit.
- Consumes decode-stage (DE_*) signals and computes the ALU, branch, jump, address and CSR results.
- Runs a single-cycle RV32M multiply, an iterative 32-step divider, and a two-cycle AMO read-modify sequence.
- Registers all results into the EM_* pipeline register consumed by the memory stage. Stalls upstream during multi-cycle operations.

---
 rtl/execute_unit_pkg.sv | 44 ++++
 rtl/execute_unit_divider.sv | 78 +++++++
 rtl/execute_unit.sv | 217 +++++++++++++++++++++
 tb/tb_execute_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_unit_pkg.sv
// rtl/execute_unit_pkg.sv - shared constants and FSM state type for the execute stage
package execute_unit_pkg;

    // ALU funct3 encodings (OP / OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // M-extension funct7
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // AMO funct5 (funct7[6:2]); LR/SC shared with the memory stage decode
    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_AMO_RD = 2'd2
    } exec_state_e;

endpackage

// File: rtl/execute_unit_divider.sv
// rtl/execute_unit_divider.sv - iterative radix-2 restoring divider with sign correction
// Ports: clk_i/reset_i (async active-high), start_i loads operands and performs step 1,
//        signed_i selects signed division, dividend_i/divisor_i raw operands,
//        busy_o high while steps remain, quotient_o/remainder_o sign-corrected results.
module divider_iter #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);
    localparam int              CW   = $clog2(DIV_STEPS + 1);
    localparam logic [CW-1:0]   LAST = CW'(DIV_STEPS);

    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic          neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_mag, b_mag;
    logic [31:0]   step_rem, step_quo, step_dsr;
    logic [32:0]   rem_shift, trial;

    assign a_mag  = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    assign b_mag  = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
    assign busy_o = (cnt_q != '0) && (cnt_q != LAST);

    always_comb begin
        // The first step is folded into the load so that 32 steps fit in 32 stall cycles.
        step_rem  = start_i ? 32'd0 : rem_q;
        step_quo  = start_i ? a_mag : quo_q;
        step_dsr  = start_i ? b_mag : dsr_q;
        rem_shift = {step_rem, step_quo[31]};
        trial     = rem_shift - {1'b0, step_dsr};   // trial[32] set means borrow: keep remainder
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (start_i || busy_o) begin
            rem_d = trial[32] ? rem_shift[31:0] : trial[31:0];
            quo_d = {step_quo[30:0], ~trial[32]};
            dsr_d = step_dsr;
            cnt_d = start_i ? CW'(1) : cnt_q + CW'(1);
        end
        if (start_i) begin
            neg_quo_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
            neg_rem_d = signed_i && dividend_i[31];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
    assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - RV32IMA execute stage: ALU, branch, CSR, MUL, iterative DIV, AMO; EM register
// Ports: clk_i/reset_i (async active-high); DE_* decoded instruction and forwarded operands;
//        DMemRAddr_o/DMemRData_i synchronous data-memory read; E_stall_o, E_jumpOrBranch_o,
//        E_jumpAddr_o to upstream; EM_* registered pipeline outputs to the memory stage.
module execute_unit import execute_unit_pkg::*; #(
    parameter int DIV_STEPS = 32,
    parameter int IO_BIT    = 22
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] DE_PC_i,
    input  logic [31:0] DE_instr_i,
    input  logic        DE_nop_i,
    input  logic        DE_isALUreg_i, DE_isALUimm_i, DE_isBranch_i, DE_isJAL_i,
    input  logic        DE_isJALR_i, DE_isLUI_i, DE_isAUIPC_i,
    input  logic        DE_isLoad_i, DE_isStore_i, DE_isCSR_i, DE_isAMO_i,
    input  logic [5:0]  DE_rdId_i, DE_rs1Id_i, DE_rs2Id_i,
    input  logic [11:0] DE_csrId_i,
    input  logic [31:0] DE_rs1_i, DE_rs2_i, DE_imm_i,
    input  logic [31:0] DE_CSRdata_i,
    input  logic [2:0]  DE_funct3_i,
    input  logic [6:0]  DE_funct7_i,
    input  logic        DE_wbEnable_i,
    output logic [31:0] DMemRAddr_o,
    input  logic [31:0] DMemRData_i,
    output logic        E_stall_o,
    output logic        E_jumpOrBranch_o,
    output logic [31:0] E_jumpAddr_o,
    output logic [31:0] EM_PC_o, EM_instr_o,
    output logic        EM_nop_o, EM_isLoad_o, EM_isStore_o, EM_isCSR_o, EM_isAMO_o, EM_wbEnable_o,
    output logic [5:0]  EM_rdId_o, EM_rs1Id_o, EM_rs2Id_o,
    output logic [11:0] EM_csrId_o,
    output logic [31:0] EM_rs2_o, EM_Eresult_o, EM_addr_o, EM_CSRdata_o,
    output logic [2:0]  EM_funct3_o,
    output logic [6:0]  EM_funct7_o
);
    exec_state_e state_q, state_d;

    logic [31:0] addr_sum, addr, op2, alu_out, csr_src, csr_out, amo_out, mul_out, div_out, result;
    logic [4:0]  shamt, amo_f5;
    logic        taken, is_muldiv, is_div, div_signed, div_zero, div_ovf, amo_multi;
    logic        div_start, div_busy;
    logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
    logic [32:0] mul_a, mul_b;
    logic signed [65:0] mul_prod;
    logic [1:0]  unused_prod_bits;
    logic        unused_io_sel;

    assign addr_sum    = DE_rs1_i + DE_imm_i;
    assign addr        = DE_isAMO_i ? DE_rs1_i : addr_sum;
    assign DMemRAddr_o = addr;
    // IO space is decoded downstream; the select bit is only named here.
    assign unused_io_sel = addr[IO_BIT];

    // ---------------- ALU ----------------
    assign op2   = DE_isALUreg_i ? DE_rs2_i : DE_imm_i;
    assign shamt = op2[4:0];
    always_comb begin
        alu_out = '0;
        case (DE_funct3_i)
            F3_ADD:  alu_out = (DE_isALUreg_i && DE_funct7_i[5]) ? DE_rs1_i - op2 : DE_rs1_i + op2;
            F3_SLL:  alu_out = DE_rs1_i << shamt;
            F3_SLT:  alu_out = {31'd0, $signed(DE_rs1_i) < $signed(op2)};
            F3_SLTU: alu_out = {31'd0, DE_rs1_i < op2};
            F3_XOR:  alu_out = DE_rs1_i ^ op2;
            F3_SR:   alu_out = DE_funct7_i[5] ? 32'($signed(DE_rs1_i) >>> shamt) : DE_rs1_i >> shamt;
            F3_OR:   alu_out = DE_rs1_i | op2;
            F3_AND:  alu_out = DE_rs1_i & op2;
            default: alu_out = '0;
        endcase
    end

    // ---------------- branch ----------------
    always_comb begin
        taken = 1'b0;
        case (DE_funct3_i)
            F3_BEQ:  taken = DE_rs1_i == DE_rs2_i;
            F3_BNE:  taken = DE_rs1_i != DE_rs2_i;
            F3_BLT:  taken = $signed(DE_rs1_i) <  $signed(DE_rs2_i);
            F3_BGE:  taken = $signed(DE_rs1_i) >= $signed(DE_rs2_i);
            F3_BLTU: taken = DE_rs1_i <  DE_rs2_i;
            F3_BGEU: taken = DE_rs1_i >= DE_rs2_i;
            default: taken = 1'b0;
        endcase
    end
    assign E_jumpAddr_o     = DE_isJALR_i ? {addr_sum[31:1], 1'b0} : DE_PC_i + DE_imm_i;
    assign E_jumpOrBranch_o = !DE_nop_i && !E_stall_o &&
                              (DE_isJAL_i || DE_isJALR_i || (DE_isBranch_i && taken));

    // ---------------- CSR ----------------
    assign csr_src = DE_funct3_i[2] ? {27'd0, DE_rs1Id_i[4:0]} : DE_rs1_i;
    always_comb begin
        csr_out = DE_CSRdata_i;
        case (DE_funct3_i[1:0])
            2'b01:   csr_out = csr_src;
            2'b10:   csr_out = DE_CSRdata_i | csr_src;
            2'b11:   csr_out = DE_CSRdata_i & ~csr_src;
            default: csr_out = DE_CSRdata_i;
        endcase
    end

    // ---------------- AMO ----------------
    assign amo_f5    = DE_funct7_i[6:2];
    assign amo_multi = DE_isAMO_i && (amo_f5 != AMO_LR) && (amo_f5 != AMO_SC);
    always_comb begin
        amo_out = DE_rs2_i;
        case (amo_f5)
            AMO_SWAP: amo_out = DE_rs2_i;
            AMO_ADD:  amo_out = DMemRData_i + DE_rs2_i;
            AMO_XOR:  amo_out = DMemRData_i ^ DE_rs2_i;
            AMO_AND:  amo_out = DMemRData_i & DE_rs2_i;
            AMO_OR:   amo_out = DMemRData_i | DE_rs2_i;
            AMO_MIN:  amo_out = ($signed(DMemRData_i) < $signed(DE_rs2_i)) ? DMemRData_i : DE_rs2_i;
            AMO_MAX:  amo_out = ($signed(DMemRData_i) > $signed(DE_rs2_i)) ? DMemRData_i : DE_rs2_i;
            AMO_MINU: amo_out = (DMemRData_i < DE_rs2_i) ? DMemRData_i : DE_rs2_i;
            AMO_MAXU: amo_out = (DMemRData_i > DE_rs2_i) ? DMemRData_i : DE_rs2_i;
            default:  amo_out = DE_rs2_i;   // LR / SC
        endcase
    end

    // ---------------- MUL / DIV ----------------
    assign is_muldiv = DE_isALUreg_i && (DE_funct7_i == F7_MULDIV);
    assign is_div    = is_muldiv && DE_funct3_i[2];
    // MULHU is the only form with an unsigned rs1; only MULH (and MUL, whose low half is sign-agnostic) treat rs2 as signed.
    assign mul_a = {(DE_funct3_i != 3'b011) & DE_rs1_i[31], DE_rs1_i};
    assign mul_b = {(DE_funct3_i[1] == 1'b0) & DE_rs2_i[31], DE_rs2_i};
    assign mul_prod = $signed(mul_a) * $signed(mul_b);
    assign unused_prod_bits = mul_prod[65:64];
    assign mul_out = (DE_funct3_i[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

    assign div_signed = !DE_funct3_i[0];
    assign div_zero   = DE_rs2_i == 32'd0;
    assign div_ovf    = div_signed && (DE_rs1_i == 32'h8000_0000) && (DE_rs2_i == 32'hFFFF_FFFF);
    assign quo_fix    = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : div_quo);
    assign rem_fix    = div_zero ? DE_rs1_i      : (div_ovf ? 32'd0         : div_rem);
    assign div_out    = DE_funct3_i[1] ? rem_fix : quo_fix;

    divider_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (div_start),
        .signed_i    (div_signed),
        .dividend_i  (DE_rs1_i),
        .divisor_i   (DE_rs2_i),
        .busy_o      (div_busy),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // ---------------- result mux ----------------
    always_comb begin
        result = alu_out;
        if (DE_isJAL_i || DE_isJALR_i) result = DE_PC_i + 32'd4;
        else if (DE_isLUI_i)           result = DE_imm_i;
        else if (DE_isAUIPC_i)         result = DE_PC_i + DE_imm_i;
        else if (DE_isCSR_i)           result = csr_out;
        else if (DE_isAMO_i)           result = amo_out;
        else if (is_muldiv)            result = DE_funct3_i[2] ? div_out : mul_out;
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d   = state_q;
        E_stall_o = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!DE_nop_i && is_div && !div_zero && !div_ovf) begin
                    state_d   = ST_DIV;
                    E_stall_o = 1'b1;
                    div_start = 1'b1;
                end else if (!DE_nop_i && amo_multi) begin
                    state_d   = ST_AMO_RD;
                    E_stall_o = 1'b1;
                end
            end
            // Last DIV cycle (divider idle) writes the real result unstalled, then leaves.
            ST_DIV: begin
                if (div_busy) E_stall_o = 1'b1;
                else          state_d   = ST_IDLE;
            end
            ST_AMO_RD: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- EM pipeline register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            EM_PC_o <= '0; EM_instr_o <= '0;
            EM_nop_o <= 1'b1; EM_isLoad_o <= 1'b0; EM_isStore_o <= 1'b0;
            EM_isCSR_o <= 1'b0; EM_isAMO_o <= 1'b0; EM_wbEnable_o <= 1'b0;
            EM_rdId_o <= '0; EM_rs1Id_o <= '0; EM_rs2Id_o <= '0; EM_csrId_o <= '0;
            EM_rs2_o <= '0; EM_Eresult_o <= '0; EM_addr_o <= '0; EM_CSRdata_o <= '0;
            EM_funct3_o <= '0; EM_funct7_o <= '0;
        end else if (E_stall_o || DE_nop_i) begin
            // Bubble: only the control flags change, data fields hold.
            EM_nop_o <= 1'b1; EM_isLoad_o <= 1'b0; EM_isStore_o <= 1'b0;
            EM_isCSR_o <= 1'b0; EM_isAMO_o <= 1'b0; EM_wbEnable_o <= 1'b0;
        end else begin
            EM_PC_o <= DE_PC_i; EM_instr_o <= DE_instr_i;
            EM_nop_o <= 1'b0; EM_isLoad_o <= DE_isLoad_i; EM_isStore_o <= DE_isStore_i;
            EM_isCSR_o <= DE_isCSR_i; EM_isAMO_o <= DE_isAMO_i; EM_wbEnable_o <= DE_wbEnable_i;
            EM_rdId_o <= DE_rdId_i; EM_rs1Id_o <= DE_rs1Id_i; EM_rs2Id_o <= DE_rs2Id_i;
            EM_csrId_o <= DE_csrId_i;
            EM_rs2_o <= DE_rs2_i; EM_Eresult_o <= result; EM_addr_o <= addr;
            EM_CSRdata_o <= DE_CSRdata_i;
            EM_funct3_o <= DE_funct3_i; EM_funct7_o <= DE_funct7_i;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed self-checking bench for execute_unit
module tb_execute_unit;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] DE_PC_i, DE_instr_i;
    logic        DE_nop_i;
    logic        DE_isALUreg_i, DE_isALUimm_i, DE_isBranch_i, DE_isJAL_i, DE_isJALR_i, DE_isLUI_i, DE_isAUIPC_i;
    logic        DE_isLoad_i, DE_isStore_i, DE_isCSR_i, DE_isAMO_i;
    logic [5:0]  DE_rdId_i, DE_rs1Id_i, DE_rs2Id_i;
    logic [11:0] DE_csrId_i;
    logic [31:0] DE_rs1_i, DE_rs2_i, DE_imm_i, DE_CSRdata_i;
    logic [2:0]  DE_funct3_i;
    logic [6:0]  DE_funct7_i;
    logic        DE_wbEnable_i;
    logic [31:0] DMemRAddr_o, DMemRData_i;
    logic        E_stall_o, E_jumpOrBranch_o;
    logic [31:0] E_jumpAddr_o;
    logic [31:0] EM_PC_o, EM_instr_o;
    logic        EM_nop_o, EM_isLoad_o, EM_isStore_o, EM_isCSR_o, EM_isAMO_o, EM_wbEnable_o;
    logic [5:0]  EM_rdId_o, EM_rs1Id_o, EM_rs2Id_o;
    logic [11:0] EM_csrId_o;
    logic [31:0] EM_rs2_o, EM_Eresult_o, EM_addr_o, EM_CSRdata_o;
    logic [2:0]  EM_funct3_o;
    logic [6:0]  EM_funct7_o;

    int checks   = 0;
    int failures = 0;
    int n_stall, n_bubble;

    execute_unit dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .DE_PC_i(DE_PC_i), .DE_instr_i(DE_instr_i), .DE_nop_i(DE_nop_i),
        .DE_isALUreg_i(DE_isALUreg_i), .DE_isALUimm_i(DE_isALUimm_i), .DE_isBranch_i(DE_isBranch_i),
        .DE_isJAL_i(DE_isJAL_i), .DE_isJALR_i(DE_isJALR_i), .DE_isLUI_i(DE_isLUI_i),
        .DE_isAUIPC_i(DE_isAUIPC_i), .DE_isLoad_i(DE_isLoad_i), .DE_isStore_i(DE_isStore_i),
        .DE_isCSR_i(DE_isCSR_i), .DE_isAMO_i(DE_isAMO_i),
        .DE_rdId_i(DE_rdId_i), .DE_rs1Id_i(DE_rs1Id_i), .DE_rs2Id_i(DE_rs2Id_i),
        .DE_csrId_i(DE_csrId_i), .DE_rs1_i(DE_rs1_i), .DE_rs2_i(DE_rs2_i), .DE_imm_i(DE_imm_i),
        .DE_CSRdata_i(DE_CSRdata_i), .DE_funct3_i(DE_funct3_i), .DE_funct7_i(DE_funct7_i),
        .DE_wbEnable_i(DE_wbEnable_i),
        .DMemRAddr_o(DMemRAddr_o), .DMemRData_i(DMemRData_i),
        .E_stall_o(E_stall_o), .E_jumpOrBranch_o(E_jumpOrBranch_o), .E_jumpAddr_o(E_jumpAddr_o),
        .EM_PC_o(EM_PC_o), .EM_instr_o(EM_instr_o), .EM_nop_o(EM_nop_o),
        .EM_isLoad_o(EM_isLoad_o), .EM_isStore_o(EM_isStore_o), .EM_isCSR_o(EM_isCSR_o),
        .EM_isAMO_o(EM_isAMO_o), .EM_wbEnable_o(EM_wbEnable_o),
        .EM_rdId_o(EM_rdId_o), .EM_rs1Id_o(EM_rs1Id_o), .EM_rs2Id_o(EM_rs2Id_o),
        .EM_csrId_o(EM_csrId_o), .EM_rs2_o(EM_rs2_o), .EM_Eresult_o(EM_Eresult_o),
        .EM_addr_o(EM_addr_o), .EM_CSRdata_o(EM_CSRdata_o),
        .EM_funct3_o(EM_funct3_o), .EM_funct7_o(EM_funct7_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous data memory: word 0x40 holds 10, everything else a marker value.
    always @(posedge clk_i) DMemRData_i <= (DMemRAddr_o == 32'h40) ? 32'd10 : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic de_clear();
        DE_PC_i = 0; DE_instr_i = 0; DE_nop_i = 1'b1;
        DE_isALUreg_i = 0; DE_isALUimm_i = 0; DE_isBranch_i = 0; DE_isJAL_i = 0; DE_isJALR_i = 0;
        DE_isLUI_i = 0; DE_isAUIPC_i = 0; DE_isLoad_i = 0; DE_isStore_i = 0; DE_isCSR_i = 0; DE_isAMO_i = 0;
        DE_rdId_i = 0; DE_rs1Id_i = 0; DE_rs2Id_i = 0; DE_csrId_i = 0;
        DE_rs1_i = 0; DE_rs2_i = 0; DE_imm_i = 0; DE_CSRdata_i = 0;
        DE_funct3_i = 0; DE_funct7_i = 0; DE_wbEnable_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // R-type op with given funct7/funct3, one-cycle result check
    task automatic rtype(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        de_clear();
        DE_nop_i = 0; DE_isALUreg_i = 1; DE_wbEnable_i = 1; DE_rdId_i = 6'd5;
        DE_funct7_i = f7; DE_funct3_i = f3; DE_rs1_i = a; DE_rs2_i = b;
        #1;
        check({tag, "_stall"}, {31'd0, E_stall_o}, 32'd0);
        tick();
        check(tag, EM_Eresult_o, exp);
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic nop, input logic exp);
        de_clear();
        DE_nop_i = nop; DE_isBranch_i = 1; DE_funct3_i = f3; DE_rs1_i = a; DE_rs2_i = b;
        DE_PC_i = 32'h100; DE_imm_i = 32'h20;
        #1;
        check(tag, {31'd0, E_jumpOrBranch_o}, {31'd0, exp});
    endtask

    // Issue a long division and measure stall length and EM bubbles
    task automatic long_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        de_clear();
        DE_nop_i = 0; DE_isALUreg_i = 1; DE_wbEnable_i = 1; DE_funct7_i = 7'b0000001;
        DE_funct3_i = f3; DE_rs1_i = a; DE_rs2_i = b;
        #1;
        n_stall = 0; n_bubble = 0;
        while (E_stall_o && n_stall < 100) begin
            n_stall++;
            tick();
            if (EM_nop_o) n_bubble++;
        end
        check({tag, "_stall_cycles"}, n_stall, 32'd32);
        check({tag, "_bubbles"}, n_bubble, 32'd32);
        tick();
        check({tag, "_result"}, EM_Eresult_o, exp);
        check({tag, "_nop"}, {31'd0, EM_nop_o}, 32'd0);
    endtask

    initial begin
        de_clear();
        reset_i = 1'b1;
        tick(); tick();
        check("rst_em_nop", {31'd0, EM_nop_o}, 32'd1);
        check("rst_em_result", EM_Eresult_o, 32'd0);
        check("rst_em_wb", {31'd0, EM_wbEnable_o}, 32'd0);
        check("rst_stall", {31'd0, E_stall_o}, 32'd0);
        check("rst_jump", {31'd0, E_jumpOrBranch_o}, 32'd0);
        reset_i = 1'b0;
        tick();

        // ADDI x1 = 5 + (-7)
        de_clear();
        DE_nop_i = 0; DE_isALUimm_i = 1; DE_wbEnable_i = 1; DE_rdId_i = 6'd1;
        DE_rs1_i = 32'd5; DE_imm_i = 32'hFFFF_FFF9; DE_funct3_i = 3'b000;
        tick();
        check("addi_result", EM_Eresult_o, 32'hFFFF_FFFE);
        check("addi_nop", {31'd0, EM_nop_o}, 32'd0);
        check("addi_wb", {31'd0, EM_wbEnable_o}, 32'd1);
        check("addi_rd", {26'd0, EM_rdId_o}, 32'd1);

        // Branches
        branch("beq_taken", 3'b000, 32'd3, 32'd3, 1'b0, 1'b1);
        check("beq_target", E_jumpAddr_o, 32'h120);
        branch("beq_nop", 3'b000, 32'd3, 32'd3, 1'b1, 1'b0);
        branch("bne_not", 3'b001, 32'd3, 32'd3, 1'b0, 1'b0);
        branch("blt_signed", 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        branch("bltu_unsigned", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();

        // ALU and MUL
        rtype("sub", 7'b0100000, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE);
        rtype("sra", 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        rtype("srl", 7'b0000000, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000);
        rtype("slt", 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1);
        rtype("sltu", 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0);
        rtype("mul", 7'b0000001, 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        rtype("mulh", 7'b0000001, 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        rtype("mulhsu", 7'b0000001, 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        rtype("mulhu", 7'b0000001, 3'b011, 32'hFFFF_FFFE, 32'd3, 32'd2);

        // JAL link value and JALR target
        de_clear();
        DE_nop_i = 0; DE_isJALR_i = 1; DE_PC_i = 32'h200; DE_rs1_i = 32'h1001; DE_imm_i = 32'h4;
        #1;
        check("jalr_target", E_jumpAddr_o, 32'h1004);
        tick();
        check("jalr_link", EM_Eresult_o, 32'h204);

        // CSRRS and LUI
        de_clear();
        DE_nop_i = 0; DE_isCSR_i = 1; DE_funct3_i = 3'b010; DE_CSRdata_i = 32'hF0; DE_rs1_i = 32'h0F;
        tick();
        check("csrrs", EM_Eresult_o, 32'hFF);
        check("csr_flag", {31'd0, EM_isCSR_o}, 32'd1);
        de_clear();
        DE_nop_i = 0; DE_isCSR_i = 1; DE_funct3_i = 3'b111; DE_CSRdata_i = 32'hFF; DE_rs1Id_i = 6'd3;
        tick();
        check("csrrci", EM_Eresult_o, 32'hFC);

        // Iterative divides
        long_div("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        long_div("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        long_div("divu", 3'b101, 32'd100, 32'd7, 32'd14);

        // Single-cycle divide corner cases
        rtype("divu_by_zero", 7'b0000001, 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF);
        rtype("remu_by_zero", 7'b0000001, 3'b111, 32'd9, 32'd0, 32'd9);
        rtype("div_overflow", 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        rtype("rem_overflow", 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // AMOADD: two-cycle read-modify
        de_clear();
        DE_nop_i = 0; DE_isAMO_i = 1; DE_wbEnable_i = 1; DE_funct3_i = 3'b010; DE_funct7_i = 7'b0000000;
        DE_rs1_i = 32'h40; DE_rs2_i = 32'd3; DE_imm_i = 32'h99;
        #1;
        check("amo_raddr", DMemRAddr_o, 32'h40);
        check("amo_stall1", {31'd0, E_stall_o}, 32'd1);
        tick();
        check("amo_bubble", {31'd0, EM_nop_o}, 32'd1);
        check("amo_stall2", {31'd0, E_stall_o}, 32'd0);
        tick();
        check("amoadd_result", EM_Eresult_o, 32'd13);
        check("amo_flag", {31'd0, EM_isAMO_o}, 32'd1);
        check("amo_addr", EM_addr_o, 32'h40);

        // LR: single cycle, result = rs2
        de_clear();
        DE_nop_i = 0; DE_isAMO_i = 1; DE_funct7_i = 7'b0001000; DE_funct3_i = 3'b010;
        DE_rs1_i = 32'h40; DE_rs2_i = 32'h55;
        #1;
        check("lr_stall", {31'd0, E_stall_o}, 32'd0);
        tick();
        check("lr_result", EM_Eresult_o, 32'h55);

        // Reset during division step 10
        de_clear();
        DE_nop_i = 0; DE_isALUreg_i = 1; DE_funct7_i = 7'b0000001; DE_funct3_i = 3'b100;
        DE_rs1_i = 32'd1000; DE_rs2_i = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        check("mid_div_stall", {31'd0, E_stall_o}, 32'd1);
        de_clear();
        reset_i = 1'b1;
        #1;
        check("abort_nop", {31'd0, EM_nop_o}, 32'd1);
        check("abort_stall", {31'd0, E_stall_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        rtype("add_after_abort", 7'b0000000, 3'b000, 32'd2, 32'd3, 32'd5);
        check("add_after_abort_nop", {31'd0, EM_nop_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
